sysmgr_rst_ctl: RTL and testbench



---
 rtl/sysmgr_rst_ctl_if.sv | 11 +
 rtl/sysmgr_rst_ctl.sv | 121 ++++++++++++
 tb/tb_sysmgr_rst_ctl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sysmgr_rst_ctl_if.sv
// PLL control and warm-boot bundle between the reset supervisor and the PLL/boot logic.
interface sysmgr_rst_ctl_if;
  logic       pll_lock;
  logic       pll_rst;
  logic [1:0] wb_sel;
  logic       wb_boot;
  logic       running;

  modport master (input pll_lock, output pll_rst, wb_sel, wb_boot, running);
  modport slave  (output pll_lock, input pll_rst, wb_sel, wb_boot, running);
endinterface

// File: rtl/sysmgr_rst_ctl.sv
// Board-clock reset/boot supervisor: holds the PLL in reset until lock, re-resets on
// lock loss/timeout, restarts on button or system request, warm-boots on a long press.
module sysmgr_rst_ctl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int DEB_CYCLES   = 4096,
  parameter int LONG_CYCLES  = 24000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  input  logic             req_rst,
  sysmgr_rst_ctl_if.master sys
);
  localparam int T_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX  = (T_MAX0 > LONG_CYCLES) ? T_MAX0 : LONG_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [TW-1:0] T_RST_END  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK_END = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_LONG_END = TW'(LONG_CYCLES - 1);
  localparam logic [DW-1:0] DEB_END    = DW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST, ST_WAIT_LOCK, ST_RUN, ST_BTN, ST_BOOT
  } state_t;

  logic [1:0]    btn_sync, req_sync, lock_sync;
  logic          btn_s, req_s, lock_s;
  logic          btn_deb;
  logic [DW-1:0] deb_cnt;
  logic          req_q, req_edge;
  logic [TW-1:0] timer;
  state_t        state, state_d;

  assign btn_s  = btn_sync[1];
  assign req_s  = req_sync[1];
  assign lock_s = lock_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync  <= 2'b11;
      req_sync  <= 2'b00;
      lock_sync <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], btn_n};
      req_sync  <= {req_sync[0], req_rst};
      lock_sync <= {lock_sync[0], sys.pll_lock};
    end
  end

  // btn_deb is active-high (pressed); counter runs only while the input disagrees with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_deb <= 1'b0;
      deb_cnt <= '0;
    end else if ((~btn_s) == btn_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_END) begin
      btn_deb <= ~btn_deb;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Edge pulse is registered so a request lands one cycle after lock-loss from the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      req_edge <= 1'b0;
    end else begin
      req_q    <= req_s;
      req_edge <= req_s & ~req_q;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_PLL_RST:   if (timer == T_RST_END) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)                   state_d = ST_RUN;
        else if (timer == T_LOCK_END) state_d = ST_PLL_RST;
      end
      ST_RUN: begin
        if (!lock_s)       state_d = ST_PLL_RST;
        else if (req_edge) state_d = ST_PLL_RST;
        else if (btn_deb)  state_d = ST_BTN;
      end
      ST_BTN: begin
        if (!lock_s)                  state_d = ST_PLL_RST;
        else if (!btn_deb)            state_d = ST_PLL_RST;
        else if (timer == T_LONG_END) state_d = ST_BOOT;
      end
      ST_BOOT:      state_d = ST_BOOT;
      default:      state_d = ST_PLL_RST;
    endcase
  end

  // Outputs are flopped from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_PLL_RST;
      timer       <= '0;
      sys.pll_rst <= 1'b1;
      sys.wb_sel  <= 2'b00;
      sys.wb_boot <= 1'b0;
      sys.running <= 1'b0;
    end else begin
      state <= state_d;
      if (state_d != state) timer <= '0;
      else if (timer != '1) timer <= timer + 1'b1;
      sys.pll_rst <= (state_d == ST_PLL_RST) || (state_d == ST_BOOT);
      sys.wb_sel  <= (state_d == ST_BOOT) ? 2'b01 : 2'b00;
      sys.wb_boot <= (state_d == ST_BOOT);
      sys.running <= (state_d == ST_RUN) || (state_d == ST_BTN);
    end
  end
endmodule

// File: tb/tb_sysmgr_rst_ctl.sv
// Scoreboard bench: stimulus queues expected output changes {cycle, outputs}; a monitor
// pops and compares on every observed output change.
module tb_sysmgr_rst_ctl;
  typedef struct { int cyc; logic [4:0] v; } exp_t;

  // {pll_rst, wb_sel[1:0], wb_boot, running}
  localparam logic [4:0] V_RST  = 5'b1_00_0_0;
  localparam logic [4:0] V_WAIT = 5'b0_00_0_0;
  localparam logic [4:0] V_RUN  = 5'b0_00_0_1;
  localparam logic [4:0] V_BOOT = 5'b1_01_1_0;

  logic clk = 1'b0;
  logic rst_n, btn_n, req_rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e_mon, e_end;
  logic [4:0] prev = 'x;
  logic [4:0] outs;

  sysmgr_rst_ctl_if sys();

  sysmgr_rst_ctl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(16), .DEB_CYCLES(8), .LONG_CYCLES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .req_rst(req_rst), .sys(sys)
  );

  assign outs = {sys.pll_rst, sys.wb_sel, sys.wb_boot, sys.running};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (outs !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, outs);
      end else begin
        e_mon = q.pop_front();
        if (e_mon.cyc != cyc || e_mon.v !== outs) begin
          errors++;
          $display("FAIL out_event got=%b at cyc %0d, want=%b at cyc %0d",
                   outs, cyc, e_mon.v, e_mon.cyc);
        end
      end
      prev = outs;
    end
  end

  function automatic void ex(int c, logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endfunction

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; btn_n = 1'b1; req_rst = 1'b0; sys.pll_lock = 1'b0;
    ex(1, V_RST);

    // lock held low: retry pattern 4 high / 16 low
    wait_cyc(2);  rst_n = 1'b1;
    ex(6, V_WAIT); ex(22, V_RST); ex(26, V_WAIT); ex(42, V_RST); ex(46, V_WAIT);

    // power-up: lock rises 10 cycles after release
    wait_cyc(50); rst_n = 1'b0; ex(51, V_RST);
    wait_cyc(52); rst_n = 1'b1; ex(56, V_WAIT);
    wait_cyc(62); sys.pll_lock = 1'b1; ex(65, V_RUN);

    // lock loss for 5 cycles
    wait_cyc(70); sys.pll_lock = 1'b0; ex(73, V_RST); ex(77, V_WAIT); ex(78, V_RUN);
    wait_cyc(75); sys.pll_lock = 1'b1;

    // bounce: never stable for 8 samples
    for (int i = 0; i < 14; i++) begin
      wait_cyc(90 + 3 * i);
      btn_n = i[0];
    end

    // short press, restart after debounced release
    wait_cyc(140); btn_n = 1'b0; ex(171, V_RST); ex(175, V_WAIT); ex(176, V_RUN);
    wait_cyc(160); btn_n = 1'b1;

    // request in RUN, then held high
    wait_cyc(190); req_rst = 1'b1; ex(194, V_RST); ex(198, V_WAIT); ex(199, V_RUN);
    wait_cyc(205); req_rst = 1'b0;

    // request edge while waiting for lock is dropped
    wait_cyc(210); sys.pll_lock = 1'b0; ex(213, V_RST); ex(217, V_WAIT); ex(228, V_RUN);
    wait_cyc(218); req_rst = 1'b1;
    wait_cyc(225); sys.pll_lock = 1'b1;
    wait_cyc(235); req_rst = 1'b0;

    // simultaneous lock loss and request: one reset pulse
    wait_cyc(245); sys.pll_lock = 1'b0; req_rst = 1'b1;
    ex(248, V_RST); ex(252, V_WAIT); ex(253, V_RUN);
    wait_cyc(250); sys.pll_lock = 1'b1;
    wait_cyc(255); req_rst = 1'b0;

    // long press into warm-boot, held until rst_n
    wait_cyc(260); btn_n = 1'b0; ex(303, V_BOOT);
    wait_cyc(320); btn_n = 1'b1;
    wait_cyc(335); rst_n = 1'b0; ex(336, V_RST); ex(341, V_WAIT); ex(342, V_RUN);
    wait_cyc(337); rst_n = 1'b1;

    wait_cyc(360);
    while (q.size() > 0) begin
      e_end = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event want=%b at cyc %0d, got none", e_end.v, e_end.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
